// File: rtl/scan_unload_ctrl.sv
// scan_unload_ctrl
//   Captures functional data into an attached scan chain, then shifts it out
//   through SO. The bits are packed LSB first into WORD_W-bit words and handed
//   to a consumer over a DVALID/DREADY handshake.
//
// Parameters
//   CHAIN_LEN : number of scan cells in the chain (1..1024)
//   WORD_W    : width of each unloaded word (1..32)
//
// Ports
//   CLK      in   clock; all state changes on its rising edge
//   CD       in   synchronous active-high clear; overrides every other input
//   START    in   request one capture-and-unload (ignored unless idle)
//   SO       in   scan-out from the chain tail cell
//   SE       out  scan enable to the chain (1 = shift, 0 = capture)
//   CHAIN_CE out  chain clock enable; the chain updates only while it is 1
//   SI       out  chain head input, held at 0
//   DOUT     out  unloaded word
//   DVALID   out  DOUT holds an unconsumed word
//   DREADY   in   consumer accepts DOUT
//   BUSY     out  high whenever the controller is not idle
//   DONE     out  one-cycle pulse when an unload completes
module scan_unload_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              CLK,
  input  logic              CD,
  input  logic              START,
  input  logic              SO,
  output logic              SE,
  output logic              CHAIN_CE,
  output logic              SI,
  output logic [WORD_W-1:0] DOUT,
  output logic              DVALID,
  input  logic              DREADY,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SHIFT   = 3'd2,
    S_DRAIN   = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     bitcnt;   // shifts taken so far in this unload
  logic [IW-1:0]     idx;      // bit position inside the word being assembled
  logic [WORD_W-1:0] asm_q;    // word under assembly, separate from DOUT
  logic [WORD_W-1:0] asm_nx;

  logic last_bit, word_end, accept, can_shift, shift_en;

  assign last_bit = (bitcnt == CW'(CHAIN_LEN - 1));
  assign word_end = last_bit || (idx == IW'(WORD_W - 1));
  assign accept   = DVALID && DREADY;
  // Only the shift that finishes a word needs DOUT to be free; every other
  // shift writes into asm_q and may proceed under backpressure.
  assign can_shift = !word_end || !DVALID || DREADY;
  assign shift_en  = (state == S_SHIFT) && can_shift;

  assign SI = 1'b0;

  // Assembly word with the current SO bit merged in at idx.
  always_comb begin
    asm_nx      = asm_q;
    asm_nx[idx] = SO;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (CD) state <= S_IDLE;
    else    state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (START) state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_SHIFT;
      S_SHIFT:   if (shift_en && last_bit) state_nx = S_DRAIN;
      S_DRAIN:   if (!DVALID || DREADY) state_nx = S_FIN;
      S_FIN:     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Outputs. A stalled shift keeps SE high but drops CHAIN_CE so the chain
  // holds its tail bit until the word can complete.
  always_comb begin
    SE       = (state == S_SHIFT);
    CHAIN_CE = (state == S_CAPTURE) || shift_en;
    BUSY     = (state != S_IDLE);
    DONE     = (state == S_FIN);
  end

  // Datapath: bit/word counters, assembly register and output word.
  always_ff @(posedge CLK) begin
    if (CD) begin
      bitcnt <= '0;
      idx    <= '0;
      asm_q  <= '0;
      DOUT   <= '0;
      DVALID <= 1'b0;
    end else begin
      if (accept) DVALID <= 1'b0;
      if (shift_en) begin
        bitcnt <= last_bit ? '0 : bitcnt + 1'b1;
        if (word_end) begin
          // Clearing asm_q here zero-fills the upper bits of a final partial word.
          DOUT   <= asm_nx;
          DVALID <= 1'b1;
          asm_q  <= '0;
          idx    <= '0;
        end else begin
          asm_q <= asm_nx;
          idx   <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_unload_ctrl.sv
// Bench for scan_unload_ctrl: two instances (16-cell and 12-cell chains,
// 8-bit words) run side by side against behavioural chain models. Expected
// words are slices of the captured value; DONE timing and word counts come
// from the unload-time and word-count rules.
module tb_scan_unload_ctrl;
  localparam int W  = 8;
  localparam int LA = 16;
  localparam int LB = 12;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic CD, START;
  logic so[2], dready[2], se[2], ce[2], si[2], dvalid[2], busy[2], done[2];
  logic [W-1:0]  dout[2];
  logic [15:0]   chain[2];
  logic [15:0]   func[2];

  int n_tests = 0;
  int n_fail  = 0;

  scan_unload_ctrl #(.CHAIN_LEN(LA), .WORD_W(W)) u_dut_a (
    .CLK(CLK), .CD(CD), .START(START), .SO(so[0]), .SE(se[0]), .CHAIN_CE(ce[0]),
    .SI(si[0]), .DOUT(dout[0]), .DVALID(dvalid[0]), .DREADY(dready[0]),
    .BUSY(busy[0]), .DONE(done[0]));

  scan_unload_ctrl #(.CHAIN_LEN(LB), .WORD_W(W)) u_dut_b (
    .CLK(CLK), .CD(CD), .START(START), .SO(so[1]), .SE(se[1]), .CHAIN_CE(ce[1]),
    .SI(si[1]), .DOUT(dout[1]), .DVALID(dvalid[1]), .DREADY(dready[1]),
    .BUSY(busy[1]), .DONE(done[1]));

  function automatic int len_of(input int i);
    return (i == 0) ? LA : LB;
  endfunction

  // Chain model: capture loads func, shift moves toward the tail (bit 0).
  assign so[0] = chain[0][0];
  assign so[1] = chain[1][0];
  initial begin
    chain[0] = '0;
    chain[1] = '0;
  end
  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (ce[i]) begin
        if (!se[i]) chain[i] <= func[i];
        else        chain[i] <= (chain[i] >> 1) | (16'(si[i]) << (len_of(i) - 1));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DREADY patterns: 0 always ready, 1 blocked until cycle 30,
  // 2 blocked over cycles 9..16, 3 random.
  function automatic logic dr(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return n >= 30;
      2:       return !(n >= 9 && n <= 16);
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic check_reset_outs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_se"},     32'(se[i]),     32'd0);
      chk({tag, "_ce"},     32'(ce[i]),     32'd0);
      chk({tag, "_si"},     32'(si[i]),     32'd0);
      chk({tag, "_dout"},   32'(dout[i]),   32'd0);
      chk({tag, "_dvalid"}, 32'(dvalid[i]), 32'd0);
      chk({tag, "_busy"},   32'(busy[i]),   32'd0);
      chk({tag, "_done"},   32'(done[i]),   32'd0);
    end
  endtask

  // One unload on both instances. Cycle n is the one observed n edges after
  // the edge that sampled START.
  task automatic unload(input logic [15:0] fa, input logic [15:0] fb, input int mode,
                        input bit start_mid, input int abort_at);
    int nw[2], rd[2], ndone[2];
    logic [W-1:0] ew[2][4];
    bit fin[2], timed[2], prev_hold[2];
    logic [W-1:0] prev_dout[2];
    func[0] = fa;
    func[1] = fb & 16'h0FFF;
    timed[0] = (mode == 0) || (mode == 2);
    timed[1] = (mode == 0);
    for (int i = 0; i < 2; i++) begin
      nw[i] = (len_of(i) + W - 1) / W;
      for (int k = 0; k < 4; k++) ew[i][k] = W'(func[i] >> (k * W));
      rd[i] = 0; ndone[i] = 0; fin[i] = 0; prev_hold[i] = 0; prev_dout[i] = '0;
    end
    @(negedge CLK);
    START = 1'b1;
    dready[0] = 1'b1; dready[1] = 1'b1;
    @(negedge CLK);
    for (int n = 1; n < 300; n++) begin
      if (abort_at > 0 && n == abort_at) begin
        CD = 1'b1; START = 1'b1;
        @(negedge CLK);
        CD = 1'b0; START = 1'b0;
        check_reset_outs("abort");
        chk("abort_nodone_a", 32'(ndone[0]), 32'd0);
        chk("abort_nodone_b", 32'(ndone[1]), 32'd0);
        return;
      end
      for (int i = 0; i < 2; i++) begin
        if (prev_hold[i]) begin
          chk("hold_dvalid", 32'(dvalid[i]), 32'd1);
          chk("hold_dout",   32'(dout[i]),   32'(prev_dout[i]));
        end
        if (timed[i] && n <= len_of(i) + 3) chk("busy_hi", 32'(busy[i]), 32'd1);
        if (timed[i] && n == len_of(i) + 4) chk("busy_lo", 32'(busy[i]), 32'd0);
        if (done[i]) begin
          ndone[i]++;
          if (timed[i]) chk("done_time", 32'(n), 32'(len_of(i) + 3));
        end
        if (ndone[i] > 0 && !busy[i]) fin[i] = 1;
        dready[i] = dr(mode, n);
        if (dvalid[i] && dready[i]) begin
          if (rd[i] < nw[i]) chk("word", 32'(dout[i]), 32'(ew[i][rd[i]]));
          else               chk("extra_word", 32'(rd[i] + 1), 32'(nw[i]));
          rd[i]++;
        end
        prev_hold[i] = dvalid[i] && !dready[i];
        prev_dout[i] = dout[i];
      end
      START = (start_mid && n == 8);
      if (fin[0] && fin[1]) break;
      @(negedge CLK);
    end
    START = 1'b0;
    chk("finished", 32'(fin[0] && fin[1]), 32'd1);
    for (int i = 0; i < 2; i++) begin
      chk("nwords", 32'(rd[i]),    32'(nw[i]));
      chk("ndone",  32'(ndone[i]), 32'd1);
    end
  endtask

  initial begin
    CD = 1'b1; START = 1'b1;
    dready[0] = 1'b1; dready[1] = 1'b1;
    func[0] = '0; func[1] = '0;
    repeat (3) @(negedge CLK);
    check_reset_outs("reset");
    CD = 1'b0; START = 1'b0;
    @(negedge CLK);

    unload(16'hA55A, 16'h0F3C, 0, 0, 0);    // basic and partial-word unload
    unload(16'hA55A, 16'h0F3C, 1, 0, 0);    // long backpressure
    unload(16'hA55A, 16'h0F3C, 0, 1, 0);    // START while busy
    unload(16'hA55A, 16'h0F3C, 2, 0, 0);    // simultaneous accept and load
    unload(16'(($urandom)), 16'(($urandom)), 0, 0, 6);  // clear mid-shift
    unload(16'(($urandom)), 16'(($urandom)), 0, 0, 0);  // fresh unload after clear
    for (int t = 0; t < 10; t++)
      unload(16'(($urandom)), 16'(($urandom)), 3, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/scan_unload_ctrl.md
SCAN_UNLOAD_CTRL -- requirements
Module: scan_unload_ctrl

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 16, meaning the number of scan cells in the attached chain (legal 1..1024).
REQ-002 The block SHALL have parameter WORD_W, default 8, meaning the width of each unloaded output word (legal 1..32).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high, with the ports listed below.
REQ-004 The block SHALL have port CLK, input, 1 bit: clock, all state changes on its rising edge.
REQ-005 The block SHALL have port CD, input, 1 bit: synchronous active-high clear.
REQ-006 The block SHALL have port START, input, 1 bit: request one capture-and-unload of the chain.
REQ-007 The block SHALL have port SO, input, 1 bit: scan-out of the chain tail cell.
REQ-008 The block SHALL have port SE, output, 1 bit: scan enable to every chain cell (1 = shift, 0 = functional capture).
REQ-009 The block SHALL have port CHAIN_CE, output, 1 bit: clock enable to the chain; the chain updates only when it is 1.
REQ-010 The block SHALL have port SI, output, 1 bit: data into the chain head, constant 0 during unload.
REQ-011 The block SHALL have port DOUT, output, WORD_W bits: unloaded word.
REQ-012 The block SHALL have port DVALID, output, 1 bit: DOUT holds an unconsumed word.
REQ-013 The block SHALL have port DREADY, input, 1 bit: consumer accepts DOUT.
REQ-014 The block SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port DONE, output, 1 bit: one-cycle pulse marking completion.

Function
REQ-016 The block SHALL implement states IDLE, CAPTURE, SHIFT, DRAIN and FIN.
REQ-017 State transitions SHALL be as follows:
- IDLE to CAPTURE on START=1.
- CAPTURE to SHIFT after exactly one cycle.
- SHIFT to DRAIN after the CHAIN_LEN-th shift.
- DRAIN to FIN when DVALID is 0, or when DVALID=1 and DREADY=1 in the same cycle.
- FIN to IDLE after one cycle.
REQ-018 In CAPTURE, SE SHALL be 0 and CHAIN_CE SHALL be 1, so the chain latches functional data on that edge.
REQ-019 A shift cycle SHALL be a SHIFT-state cycle with SE=1 and CHAIN_CE=1; on its edge, SO is written into the assembly register at bit position idx.
REQ-020 Bits SHALL be packed LSB first: the first SO bit after capture goes to DOUT[0] of word 0.
REQ-021 A word SHALL complete when idx reaches WORD_W-1 or when the chain's final bit is sampled.
REQ-022 When a word completes, the block SHALL transfer it to DOUT and set DVALID=1 on the same edge.
REQ-023 Unfilled upper bits of a final partial word SHALL be 0 (for example, CHAIN_LEN=12 and WORD_W=8 gives a second word with bits [7:4]=0).
REQ-024 A completing shift SHALL occur only if DVALID=0, or DVALID=1 and DREADY=1 in the same cycle.
REQ-025 When the condition in REQ-024 is not met, the block SHALL stall: CHAIN_CE=0, SE=1, no sample taken, and counters held.
REQ-026 Non-completing shifts SHALL proceed regardless of DVALID, because the assembly register is separate from DOUT.
REQ-027 DVALID SHALL clear on an edge where DVALID=1 and DREADY=1 and no new word is loaded on that edge.
REQ-028 DOUT SHALL stay stable while DVALID=1 and DREADY=0.
REQ-029 START SHALL be ignored in every state except IDLE.
REQ-030 Outside CAPTURE and SHIFT, CHAIN_CE SHALL be 0 and SE SHALL be 0.
REQ-031 DONE SHALL be 1 only in FIN.
REQ-032 Total unload time with DREADY held at 1 SHALL be 1 capture cycle + CHAIN_LEN shift cycles + 1 DRAIN cycle + 1 FIN cycle.
REQ-033 Word count per unload SHALL be ceil(CHAIN_LEN/WORD_W).
REQ-034 The bit counter SHALL be at least clog2(CHAIN_LEN+1) bits wide and SHALL return to 0 at unload end.

Reset
REQ-035 On CLK edge with CD=1, the block SHALL enter IDLE and clear all counters and the assembly register.
REQ-036 Reset values SHALL be: SE=0, CHAIN_CE=0, SI=0, DOUT=0, DVALID=0, BUSY=0, DONE=0.
REQ-037 CD SHALL override every other input, including START and DREADY in the same cycle.
REQ-038 If CD is asserted mid-unload, the unload SHALL be abandoned and any pending word discarded, with no DONE pulse.

Verification
REQ-039 Basic unload: CHAIN_LEN=16, WORD_W=8, chain holds 0xA55A (tail bit first = bit 0), DREADY=1, START pulse -> DOUT=0x5A then 0xA5, DONE exactly 19 cycles after START sampled, BUSY high throughout.
REQ-040 Backpressure: same setup, DREADY=0 until cycle 30 -> first word 0x5A held with DVALID=1, CHAIN_CE=0 from the 16th shift attempt, resumes when DREADY=1, second word 0xA5 is correct and no bit is lost.
REQ-041 Partial word: CHAIN_LEN=12, WORD_W=8, chain=0xF3C -> words 0x3C then 0x0F, exactly 2 words.
REQ-042 Reset mid-shift: CD=1 at shift 5 -> next cycle SE=0, CHAIN_CE=0, DVALID=0, BUSY=0, no DONE pulse; a fresh START then completes normally.
REQ-043 START while busy: pulse START during SHIFT -> no restart; word count and DONE timing are identical to REQ-039.
REQ-044 Simultaneous handshake: DVALID=1 and DREADY=1 on the edge that completes the next word -> new word loaded, DVALID stays 1, no stall cycle.
